// File: rtl/spi_peripheral.sv
// Memory-mapped SPI mode-0 target: oversampled sclk/cs_n/mosi, RX FIFO, single-byte TX holding register.
// Pin timing assumes sclk half-period >= 4 clk so every synced edge is seen exactly once.
module spi_peripheral #(
  parameter logic [31:0] ADDR      = 32'hd100,
  parameter int          RX_DEPTH  = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  output logic        irq,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RX_DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;

  state_e        state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    rx_sr_q;
  logic [7:0]    tx_sr_q;
  logic [1:0]    sclk_sync_q;
  logic [1:0]    cs_sync_q;
  logic [1:0]    mosi_sync_q;
  logic          sclk_prev_q;
  logic          cs_prev_q;
  logic [2:0]    ctrl_q;            // {irq_tx_en, irq_rx_en, enable}
  logic          flush_q;
  logic          hold_v_q, hold_v_d;
  logic [7:0]    hold_q, hold_d;
  logic [3:0]    sticky_q, sticky_d; // {tx_ovf, abort, tx_underrun, rx_overrun}
  logic [7:0]    mem_q [RX_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic sel_status_s, sel_ctrl_s, sel_tx_s, sel_rx_s;
  logic wr_ctrl_s, wr_status_s, wr_tx_s, rd_rx_s;
  logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
  logic en_s, in_shift_s, start_s, stop_s, bit_s, fall_s, reload_s;
  logic consume_s, push_s, push_ok_s, pop_s, full_s, nonempty_s;
  logic overrun_set_s, underrun_set_s, abort_set_s, tx_ovf_set_s;
  logic [7:0]  rx_byte_s, tx_load_s, head_s;
  logic [3:0]  w1c_s, cnt_field_s;
  logic [4:0]  cnt_ext_s;
  logic [31:0] status_s;
  logic        unused_s;

  assign unused_s = ^{wdata[31:8], wmask[3:1]};

  // Bus address decode and strobes.
  assign sel_status_s = (addr == ADDR);
  assign sel_ctrl_s   = (addr == ADDR + 32'd4);
  assign sel_tx_s     = (addr == ADDR + 32'd8);
  assign sel_rx_s     = (addr == ADDR + 32'd12);
  assign wr_ctrl_s    = wen & sel_ctrl_s & wmask[0];
  assign wr_status_s  = wen & sel_status_s & wmask[0];
  assign wr_tx_s      = wen & sel_tx_s & wmask[0];
  assign rd_rx_s      = ren & sel_rx_s;

  // Edges are taken between the second sync stage and a third history flop.
  assign sclk_rise_s = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_sync_q[1] & sclk_prev_q;
  assign cs_fall_s   = ~cs_sync_q[1] & cs_prev_q;
  assign cs_rise_s   = cs_sync_q[1] & ~cs_prev_q;

  assign en_s       = ctrl_q[0];
  assign in_shift_s = en_s & (state_q == ST_SHIFT);
  assign start_s    = en_s & (state_q == ST_IDLE) & cs_fall_s;
  assign stop_s     = in_shift_s & cs_rise_s;
  assign bit_s      = in_shift_s & ~cs_rise_s & sclk_rise_s;
  assign fall_s     = in_shift_s & ~cs_rise_s & sclk_fall_s;
  assign reload_s   = fall_s & (bitcnt_q == 3'd0);
  assign consume_s  = start_s | reload_s;
  assign push_s     = bit_s & (bitcnt_q == 3'd7);
  assign rx_byte_s  = {rx_sr_q[6:0], mosi_sync_q[1]};
  assign tx_load_s  = hold_v_q ? hold_q : IDLE_BYTE;

  assign full_s         = (count_q == DEPTH_C);
  assign nonempty_s     = (count_q != {CW{1'b0}});
  assign push_ok_s      = push_s & ~full_s & ~flush_q;
  assign pop_s          = rd_rx_s & nonempty_s;
  assign overrun_set_s  = push_s & full_s;
  assign underrun_set_s = consume_s & ~hold_v_q;
  assign abort_set_s    = stop_s & (bitcnt_q != 3'd0);
  assign head_s         = nonempty_s ? mem_q[rptr_q] : 8'd0;

  // Two-stage synchronizers plus edge-history flops for the SPI pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  // Frame FSM with shift registers; disabling the block parks it in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 3'd0;
      rx_sr_q  <= 8'd0;
      tx_sr_q  <= 8'd0;
    end else if (!en_s) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q  <= ST_SHIFT;
            bitcnt_q <= 3'd0;
            tx_sr_q  <= tx_load_s;
          end
        end
        ST_SHIFT: begin
          if (stop_s) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= 3'd0;
          end else if (bit_s) begin
            rx_sr_q  <= rx_byte_s;
            bitcnt_q <= bitcnt_q + 3'd1;   // wraps to 0 after the eighth bit
          end else if (reload_s) begin
            tx_sr_q  <= tx_load_s;
          end else if (fall_s) begin
            tx_sr_q  <= {tx_sr_q[6:0], 1'b0};
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          bitcnt_q <= 3'd0;
        end
      endcase
    end
  end

  // Control register; flush is a one-cycle pulse acted on by the FIFO next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= 3'd0;
      flush_q <= 1'b0;
    end else if (wr_ctrl_s) begin
      ctrl_q  <= wdata[2:0];
      flush_q <= wdata[3];
    end else begin
      flush_q <= 1'b0;
    end
  end

  // Holding register next state: a write in the consume cycle refills it.
  always_comb begin
    hold_v_d     = hold_v_q;
    hold_d       = hold_q;
    tx_ovf_set_s = 1'b0;
    if (consume_s) begin
      hold_v_d = 1'b0;
    end else begin
      hold_v_d = hold_v_q;
    end
    if (wr_tx_s) begin
      if (hold_v_q && !consume_s) begin
        tx_ovf_set_s = 1'b1;
      end else begin
        hold_d   = wdata[7:0];
        hold_v_d = 1'b1;
      end
    end else begin
      hold_d = hold_q;
    end
  end

  // Sticky status: a set in the same cycle overrides a W1C.
  always_comb begin
    w1c_s    = {4{wr_status_s}} & wdata[6:3];
    sticky_d = (sticky_q & ~w1c_s) |
               {tx_ovf_set_s, abort_set_s, underrun_set_s, overrun_set_s};
  end

  // RX FIFO pointer and occupancy next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_q) begin
      wptr_d  = {AW{1'b0}};
      rptr_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wptr_d = wptr_q + AW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + AW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Holding, sticky and FIFO state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v_q <= 1'b0;
      hold_q   <= 8'd0;
      sticky_q <= 4'd0;
      wptr_q   <= {AW{1'b0}};
      rptr_q   <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < RX_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
      sticky_q <= sticky_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      if (push_ok_s) begin
        mem_q[wptr_q] <= rx_byte_s;
      end
    end
  end

  // rx_count field is 4 bits wide; a 16-deep FIFO reports 15 when full.
  always_comb begin
    cnt_ext_s         = 5'd0;
    cnt_ext_s[CW-1:0] = count_q;
    cnt_field_s       = cnt_ext_s[4] ? 4'hF : cnt_ext_s[3:0];
  end

  assign status_s = {20'd0, cnt_field_s, 1'b0, sticky_q,
                     en_s & ~cs_sync_q[1], ~hold_v_q, nonempty_s};

  // Combinational read mux; TXDATA is write-only.
  always_comb begin
    rdata = 32'd0;
    if (sel_status_s) begin
      rdata = status_s;
    end else if (sel_ctrl_s) begin
      rdata = {29'd0, ctrl_q};
    end else if (sel_rx_s) begin
      rdata = {23'd0, nonempty_s, head_s};
    end else begin
      rdata = 32'd0;
    end
  end

  assign ready   = 1'b1;
  assign active  = sel_status_s | sel_ctrl_s | sel_tx_s | sel_rx_s;
  assign irq     = (ctrl_q[1] & nonempty_s) | (ctrl_q[2] & ~hold_v_q);
  assign miso    = tx_sr_q[7];
  assign miso_oe = en_s & ~cs_sync_q[1];

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: drives an SPI mode-0 controller and the bus, compares against a
// queue-based model of holding register, RX FIFO and sticky flags.
module tb_spi_peripheral;

  localparam logic [31:0] BASE  = 32'hd100;
  localparam int          DEPTH = 4;
  localparam int          HP    = 8;

  logic        clk, reset;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wmask;
  logic        wen, ren, ready, active, irq;
  logic        sclk, cs_n, mosi, miso, miso_oe;

  int errors = 0;
  int checks = 0;

  bit         m_en, m_rxie, m_txie, m_hv, m_ovr, m_udr, m_abt, m_ovf;
  logic [7:0] m_hold;
  logic [7:0] m_fifo[$];
  logic [7:0] g_tx[$];
  logic [7:0] g_rx[$];
  logic [7:0] g_exp[$];

  spi_peripheral #(.ADDR(BASE), .RX_DEPTH(DEPTH), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .wmask(wmask),
    .wen(wen), .ren(ren), .rdata(rdata), .ready(ready), .active(active),
    .irq(irq), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  function automatic logic [31:0] exp_status();
    logic [3:0] c;
    c = 4'(m_fifo.size());
    return {20'd0, c, 1'b0, m_ovf, m_abt, m_udr, m_ovr, 1'b0, ~m_hv, m_fifo.size() != 0};
  endfunction

  function automatic logic [31:0] exp_rx();
    if (m_fifo.size() == 0) return 32'd0;
    return {23'd0, 1'b1, m_fifo[0]};
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    addr = a; wdata = d; wmask = m; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0; wmask = 4'h0; addr = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; ren = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    ren = 1'b0; addr = 32'd0;
  endtask

  task automatic set_ctrl(input bit en, input bit rxie, input bit txie);
    bus_write(BASE + 32'd4, {29'd0, txie, rxie, en}, 4'h1);
    m_en = en; m_rxie = rxie; m_txie = txie;
  endtask

  task automatic load_tx(input logic [7:0] b);
    bus_write(BASE + 32'd8, {24'd0, b}, 4'h1);
    if (m_hv) m_ovf = 1'b1;
    else begin m_hold = b; m_hv = 1'b1; end
  endtask

  task automatic w1c(input logic [7:0] mask);
    bus_write(BASE, {24'd0, mask}, 4'h1);
    if (mask[3]) m_ovr = 1'b0;
    if (mask[4]) m_udr = 1'b0;
    if (mask[5]) m_abt = 1'b0;
    if (mask[6]) m_ovf = 1'b0;
  endtask

  // Model of one frame: a byte is taken from holding at select and after every full byte.
  task automatic model_frame(input int nbits);
    int f;
    f = nbits / 8;
    g_exp = {};
    if (!m_en) return;
    for (int k = 0; k <= f; k++) begin
      if (m_hv) begin g_exp.push_back(m_hold); m_hv = 1'b0; end
      else begin g_exp.push_back(8'hFF); m_udr = 1'b1; end
      if (k < f) begin
        if (m_fifo.size() == DEPTH) m_ovr = 1'b1;
        else m_fifo.push_back(g_tx[k]);
      end
    end
    if (nbits % 8 != 0) m_abt = 1'b1;
  endtask

  task automatic spi_frame(input int nbits, input bit watch_irq);
    logic [7:0] cur, b;
    cur = 8'd0;
    g_rx = {};
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HP) @(negedge clk);
    checks++;
    if (miso_oe !== m_en) begin
      errors++;
      $display("FAIL miso_oe_in_frame: got %b expected %b", miso_oe, m_en);
    end
    for (int i = 0; i < nbits; i++) begin
      b = g_tx[i / 8];
      mosi = b[7 - (i % 8)];
      repeat (HP) @(negedge clk);
      cur = {cur[6:0], miso};
      sclk = 1'b1;
      for (int c = 1; c <= HP; c++) begin
        @(negedge clk);
        if (watch_irq && i == nbits - 1 && c == 1) begin
          checks++;
          if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_push: got %b expected 0", irq); end
        end
        if (watch_irq && i == nbits - 1 && c == 4) begin
          checks++;
          if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_push: got %b expected 1", irq); end
        end
      end
      sclk = 1'b0;
      if (i % 8 == 7) g_rx.push_back(cur);
    end
    repeat (HP) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_read(BASE, d);
    checks++; if (d !== 32'h002) begin errors++; $display("FAIL reset_status: got %h expected 002", d); end
    bus_read(BASE + 32'd4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_control: got %h expected 0", d); end
    checks++; if (miso_oe !== 1'b0 || irq !== 1'b0 || miso !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got oe=%b irq=%b miso=%b expected 0 0 0", miso_oe, irq, miso);
    end
    addr = BASE + 32'd12;
    #1;
    checks++; if (active !== 1'b1 || ready !== 1'b1) begin
      errors++; $display("FAIL decode_mapped: got active=%b ready=%b expected 1 1", active, ready);
    end
    addr = BASE + 32'd16;
    #1;
    checks++; if (active !== 1'b0 || rdata !== 32'd0) begin
      errors++; $display("FAIL decode_unmapped: got active=%b rdata=%h expected 0 0", active, rdata);
    end
    addr = 32'd0;
  endtask

  task automatic test_basic();
    logic [31:0] d, e;
    set_ctrl(1'b1, 1'b0, 1'b0);
    load_tx(8'hA5);
    g_tx = {8'h3C};
    model_frame(8);
    spi_frame(8, 1'b0);
    checks++; if (g_rx[0] !== g_exp[0]) begin errors++; $display("FAIL basic_miso: got %h expected %h", g_rx[0], g_exp[0]); end
    bus_read(BASE, d);
    e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL basic_status: got %h expected %h", d, e); end
    for (int k = 0; k < 2; k++) begin
      e = exp_rx();
      bus_read(BASE + 32'd12, d);
      checks++; if (d !== e) begin errors++; $display("FAIL basic_rxdata%0d: got %h expected %h", k, d, e); end
      if (m_fifo.size() != 0) void'(m_fifo.pop_front());
    end
  endtask

  task automatic test_underrun();
    logic [31:0] d, e;
    w1c(8'h78);
    load_tx(8'h5A);
    g_tx = {8'h11, 8'h22};
    model_frame(16);
    spi_frame(16, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (g_rx[k] !== g_exp[k]) begin errors++; $display("FAIL underrun_miso%0d: got %h expected %h", k, g_rx[k], g_exp[k]); end
    end
    bus_read(BASE, d);
    e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL underrun_status: got %h expected %h", d, e); end
    w1c(8'h10);
    bus_read(BASE, d);
    e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL underrun_w1c: got %h expected %h", d, e); end
    for (int k = 0; k < 2; k++) begin
      e = exp_rx();
      bus_read(BASE + 32'd12, d);
      checks++; if (d !== e) begin errors++; $display("FAIL underrun_rxdata%0d: got %h expected %h", k, d, e); end
      if (m_fifo.size() != 0) void'(m_fifo.pop_front());
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d, e;
    g_tx = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    model_frame(40);
    spi_frame(40, 1'b0);
    bus_read(BASE, d);
    e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL overrun_status: got %h expected %h", d, e); end
    for (int k = 0; k < 5; k++) begin
      e = exp_rx();
      bus_read(BASE + 32'd12, d);
      checks++; if (d !== e) begin errors++; $display("FAIL overrun_rxdata%0d: got %h expected %h", k, d, e); end
      if (m_fifo.size() != 0) void'(m_fifo.pop_front());
    end
  endtask

  task automatic test_abort();
    logic [31:0] d, e;
    w1c(8'h78);
    g_tx = {8'hA0};
    model_frame(3);
    spi_frame(3, 1'b0);
    bus_read(BASE, d);
    e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL abort_status: got %h expected %h", d, e); end
    g_tx = {8'hC3};
    model_frame(8);
    spi_frame(8, 1'b0);
    e = exp_rx();
    bus_read(BASE + 32'd12, d);
    checks++; if (d !== e) begin errors++; $display("FAIL abort_next_frame: got %h expected %h", d, e); end
    if (m_fifo.size() != 0) void'(m_fifo.pop_front());
  endtask

  task automatic test_irq();
    logic [31:0] d, e;
    set_ctrl(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
    g_tx = {8'h77};
    model_frame(8);
    spi_frame(8, 1'b1);
    e = exp_rx();
    bus_read(BASE + 32'd12, d);
    checks++; if (d !== e) begin errors++; $display("FAIL irq_rxdata: got %h expected %h", d, e); end
    if (m_fifo.size() != 0) void'(m_fifo.pop_front());
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_pop: got %b expected 0", irq); end
    load_tx(8'h11);
    load_tx(8'h22);
    bus_read(BASE, d);
    e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL tx_ovf_status: got %h expected %h", d, e); end
    g_tx = {8'h99};
    model_frame(8);
    spi_frame(8, 1'b0);
    checks++; if (g_rx[0] !== g_exp[0]) begin errors++; $display("FAIL tx_ovf_keep: got %h expected %h", g_rx[0], g_exp[0]); end
    e = exp_rx();
    bus_read(BASE + 32'd12, d);
    checks++; if (d !== e) begin errors++; $display("FAIL tx_ovf_rxdata: got %h expected %h", d, e); end
    if (m_fifo.size() != 0) void'(m_fifo.pop_front());
    set_ctrl(1'b1, 1'b0, 1'b1);
    checks++; if (irq !== !m_hv) begin errors++; $display("FAIL irq_tx_empty: got %b expected %b", irq, !m_hv); end
    load_tx(8'h33);
    checks++; if (irq !== !m_hv) begin errors++; $display("FAIL irq_tx_loaded: got %b expected %b", irq, !m_hv); end
    set_ctrl(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    logic [31:0] d, e;
    g_tx = {8'hAB, 8'hCD};
    model_frame(16);
    spi_frame(16, 1'b0);
    bus_write(BASE + 32'd4, 32'h9, 4'h1);
    m_fifo.delete();
    bus_read(BASE, d);
    e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL flush_status: got %h expected %h", d, e); end
    bus_read(BASE + 32'd4, d);
    checks++; if (d !== {29'd0, m_txie, m_rxie, m_en}) begin
      errors++; $display("FAIL flush_selfclear: got %h expected %h", d, {29'd0, m_txie, m_rxie, m_en});
    end
  endtask

  task automatic test_disable();
    logic [31:0] d, e;
    set_ctrl(1'b0, 1'b0, 1'b0);
    g_tx = {8'h5E};
    model_frame(8);
    spi_frame(8, 1'b0);
    bus_read(BASE, d);
    e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL disable_status: got %h expected %h", d, e); end
    set_ctrl(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    int nbytes, nbits, nreads;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
      if ($urandom_range(0, 3) == 0) load_tx(8'($urandom));
      nbytes = $urandom_range(1, 3);
      g_tx = {};
      for (int k = 0; k < nbytes; k++) g_tx.push_back(8'($urandom));
      nbits = nbytes * 8;
      if ($urandom_range(0, 3) == 0) nbits = (nbytes - 1) * 8 + $urandom_range(1, 7);
      model_frame(nbits);
      spi_frame(nbits, 1'b0);
      for (int k = 0; k < nbits / 8; k++) begin
        checks++;
        if (g_rx[k] !== g_exp[k]) begin errors++; $display("FAIL rand%0d_miso%0d: got %h expected %h", it, k, g_rx[k], g_exp[k]); end
      end
      bus_read(BASE, d);
      e = exp_status();
      checks++; if (d !== e) begin errors++; $display("FAIL rand%0d_status: got %h expected %h", it, d, e); end
      nreads = $urandom_range(0, 3);
      for (int k = 0; k < nreads; k++) begin
        e = exp_rx();
        bus_read(BASE + 32'd12, d);
        checks++; if (d !== e) begin errors++; $display("FAIL rand%0d_rxdata%0d: got %h expected %h", it, k, d, e); end
        if (m_fifo.size() != 0) void'(m_fifo.pop_front());
      end
      if ($urandom_range(0, 2) == 0) w1c(8'($urandom_range(0, 15)) << 3);
    end
  endtask

  initial begin
    reset = 1'b1; addr = 32'd0; wdata = 32'd0; wmask = 4'h0; wen = 1'b0; ren = 1'b0;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    m_en = 1'b0; m_rxie = 1'b0; m_txie = 1'b0; m_hv = 1'b0; m_hold = 8'd0;
    m_ovr = 1'b0; m_udr = 1'b0; m_abt = 1'b0; m_ovf = 1'b0;
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_abort();
    test_irq();
    test_flush();
    test_disable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
